minibyte_bus_ctrl: RTL and testbench

Parametrised memory/IO bus controller between the Minibyte CPU core and the external pins. It decodes each CPU access to one of NUM_DEV devices (external bus, demo ROM, scratch RAM, …) by upper address bits and applies that device's programmable wait-state count. It drives address, write-enable and data output-enable, and returns registered read data with a ready handshake. It replaces the fixed input mux and drive-enable fanout with stall-capable, multi-device access sequencing.

---
 rtl/minibyte_bus_pkg.sv | 28 ++
 rtl/minibyte_wait_counter.sv | 35 +++
 rtl/minibyte_bus_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_minibyte_bus_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minibyte_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : minibyte_bus_pkg
//  Purpose  : Shared types and helpers for the Minibyte bus controller.
//             Holds the access-sequencer state encoding, the device-index
//             width helper and the value returned for unmapped reads.
//  Revision : 1.0  initial release
// ============================================================================
package minibyte_bus_pkg;

  // Access sequencer states. TURN exists only when turnaround is compiled in.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    TURN   = 2'd3
  } bus_state_e;

  // Width of the device index carved from the top address bits.
  function automatic int dev_w_f(input int num_dev);
    dev_w_f = (num_dev < 2) ? 1 : $clog2(num_dev);
  endfunction

  // Read data returned when the index decodes to no device.
  localparam int UNMAPPED_RDATA = 0;

endpackage
`default_nettype wire

// File: rtl/minibyte_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module   : minibyte_wait_counter
//  Purpose  : Wait-state down-counter. Loads a per-device wait count, counts
//             down one per decrement request and saturates at zero.
//  Revision : 1.0  initial release
// ============================================================================
module minibyte_wait_counter #(
  parameter int WAIT_W = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              load_in,
  input  logic [WAIT_W-1:0] load_val_in,
  input  logic              dec_in,
  output logic              zero_out
);

  logic [WAIT_W-1:0] cnt_q;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (load_in) begin
      cnt_q <= load_val_in;
    end else if (dec_in && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_out = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/minibyte_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : minibyte_bus_ctrl
//  Purpose  : Minibyte CPU memory/IO bus controller. Decodes each access to
//             one of NUM_DEV devices by upper address bits, inserts that
//             device's wait states, drives the bus and returns registered
//             read data with a one-cycle ready pulse.
//  Options  : MINIBYTE_BUS_TURNAROUND_EN - adds a dead TURN cycle after
//             every write so the data pads are released before the next
//             access.
//  Revision : 1.0  initial release
// ============================================================================
module minibyte_bus_ctrl
  import minibyte_bus_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int NUM_DEV = 4,
  parameter int WAIT_W  = 3
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        cpu_req_in,
  input  logic                        cpu_we_in,
  input  logic [ADDR_W-1:0]           cpu_addr_in,
  input  logic [DATA_W-1:0]           cpu_wdata_in,
  output logic [DATA_W-1:0]           cpu_rdata_out,
  output logic                        cpu_ready_out,
  input  logic [NUM_DEV*WAIT_W-1:0]   wait_cfg_in,
  input  logic [NUM_DEV*DATA_W-1:0]   dev_rdata_in,
  output logic [NUM_DEV-1:0]          dev_sel_out,
  output logic [ADDR_W-1:0]           bus_addr_out,
  output logic [DATA_W-1:0]           bus_wdata_out,
  output logic                        bus_we_out,
  output logic [DATA_W-1:0]           bus_oe_out
);

  localparam int DEV_W = dev_w_f(NUM_DEV);

  bus_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic [DEV_W-1:0]  idx_q;
  logic              mapped_q;

  logic [DEV_W-1:0]  idx_w;
  logic              mapped_w;
  logic [WAIT_W-1:0] load_val_w;
  logic              load_w;
  logic              dec_w;
  logic              cnt_zero_w;
  logic [NUM_DEV-1:0] onehot_w;
  logic [NUM_DEV-1:0] sel_w;
  logic              bus_we_w;
  logic              oe_w;
  logic              ready_w;

  logic [WAIT_W-1:0] wait_arr_w  [NUM_DEV];
  logic [DATA_W-1:0] rdata_arr_w [NUM_DEV];

  assign idx_w = cpu_addr_in[ADDR_W-1 -: DEV_W];

  // A power-of-two device count decodes every index; otherwise the top
  // indices are unmapped.
  generate
    if ((1 << DEV_W) == NUM_DEV) begin : g_full_map
      assign mapped_w = 1'b1;
    end else begin : g_part_map
      assign mapped_w = ({1'b0, idx_w} < (DEV_W + 1)'(NUM_DEV));
    end
  endgenerate

  generate
    for (genvar d = 0; d < NUM_DEV; d++) begin : g_dev
      assign wait_arr_w[d]  = wait_cfg_in[d*WAIT_W +: WAIT_W];
      assign rdata_arr_w[d] = dev_rdata_in[d*DATA_W +: DATA_W];
    end
  endgenerate

  // Unmapped accesses complete with zero wait states.
  assign load_val_w = mapped_w ? wait_arr_w[idx_w] : '0;
  assign onehot_w   = NUM_DEV'(1) << idx_q;

  minibyte_wait_counter #(
    .WAIT_W (WAIT_W)
  ) u_wait_counter (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load_in     (load_w),
    .load_val_in (load_val_w),
    .dec_in      (dec_w),
    .zero_out    (cnt_zero_w)
  );

  // Sequencer state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the access attributes when a request is accepted in IDLE.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      mapped_q <= 1'b0;
    end else if (load_w) begin
      addr_q   <= cpu_addr_in;
      wdata_q  <= cpu_wdata_in;
      we_q     <= cpu_we_in;
      idx_q    <= idx_w;
      mapped_q <= mapped_w;
    end
  end

  // Read data is captured on the edge that enters DONE, so it is already
  // valid during the ready cycle and holds until the next read completes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rdata_q <= '0;
    end else if ((state_q == ACCESS) && cnt_zero_w && !we_q) begin
      rdata_q <= mapped_q ? rdata_arr_w[idx_q] : DATA_W'(UNMAPPED_RDATA);
    end
  end

  // Next-state and bus-control decode.
  always_comb begin
    state_d  = state_q;
    load_w   = 1'b0;
    dec_w    = 1'b0;
    sel_w    = '0;
    bus_we_w = 1'b0;
    oe_w     = 1'b0;
    ready_w  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_in) begin
          load_w  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        sel_w    = mapped_q ? onehot_w : '0;
        bus_we_w = we_q && mapped_q;
        oe_w     = we_q && mapped_q;
        if (cnt_zero_w) begin
          state_d = DONE;
        end else begin
          dec_w = 1'b1;
        end
      end
      DONE: begin
        // Select and output enables stay up so the device drives (read)
        // or the pads keep holding data (write) through the ready cycle.
        sel_w   = mapped_q ? onehot_w : '0;
        oe_w    = we_q && mapped_q;
        ready_w = 1'b1;
`ifdef MINIBYTE_BUS_TURNAROUND_EN
        state_d = we_q ? TURN : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef MINIBYTE_BUS_TURNAROUND_EN
      TURN: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dev_sel_out   = sel_w;
  assign bus_we_out    = bus_we_w;
  assign bus_oe_out    = {DATA_W{oe_w}};
  assign cpu_ready_out = ready_w;
  assign cpu_rdata_out = rdata_q;
  assign bus_addr_out  = addr_q;
  assign bus_wdata_out = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_minibyte_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_minibyte_bus_ctrl
//  Purpose  : Self-checking bench for minibyte_bus_ctrl. A transaction-level
//             model expands each accepted request into its expected cycle
//             schedule; directed scenarios add hand-computed expectations.
//             A second instance with NUM_DEV=3 exercises the unmapped index.
//  Revision : 1.0  initial release
// ============================================================================
module tb_minibyte_bus_ctrl;

`ifdef MINIBYTE_BUS_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [6:0]  addr  = '0;
  logic [7:0]  wdata = '0;

  logic [2:0]  cfg  [4];
  logic [7:0]  devd [4];

  logic [11:0] wait_cfg4;
  logic [31:0] dev_rdata4;
  logic [8:0]  wait_cfg3;
  logic [23:0] dev_rdata3;

  logic [7:0]  rdata4, wdata_o4, oe4;
  logic [6:0]  baddr4;
  logic [3:0]  sel4;
  logic        rdy4, we4;

  logic [7:0]  rdata3, wdata_o3, oe3;
  logic [6:0]  baddr3;
  logic [2:0]  sel3;
  logic        rdy3, we3;

  assign wait_cfg4  = {cfg[3], cfg[2], cfg[1], cfg[0]};
  assign dev_rdata4 = {devd[3], devd[2], devd[1], devd[0]};
  assign wait_cfg3  = {cfg[2], cfg[1], cfg[0]};
  assign dev_rdata3 = {devd[2], devd[1], devd[0]};

  always #5 clk = ~clk;

  minibyte_bus_ctrl u_dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .cpu_req_in    (req),
    .cpu_we_in     (we),
    .cpu_addr_in   (addr),
    .cpu_wdata_in  (wdata),
    .cpu_rdata_out (rdata4),
    .cpu_ready_out (rdy4),
    .wait_cfg_in   (wait_cfg4),
    .dev_rdata_in  (dev_rdata4),
    .dev_sel_out   (sel4),
    .bus_addr_out  (baddr4),
    .bus_wdata_out (wdata_o4),
    .bus_we_out    (we4),
    .bus_oe_out    (oe4)
  );

  minibyte_bus_ctrl #(.NUM_DEV(3)) u_dut3 (
    .clk_in        (clk),
    .rst_in        (rst),
    .cpu_req_in    (req),
    .cpu_we_in     (we),
    .cpu_addr_in   (addr),
    .cpu_wdata_in  (wdata),
    .cpu_rdata_out (rdata3),
    .cpu_ready_out (rdy3),
    .wait_cfg_in   (wait_cfg3),
    .dev_rdata_in  (dev_rdata3),
    .dev_sel_out   (sel3),
    .bus_addr_out  (baddr3),
    .bus_wdata_out (wdata_o3),
    .bus_we_out    (we3),
    .bus_oe_out    (oe3)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [3:0] sel;
    logic       we;
    logic [7:0] oe;
    logic       rdy;
    logic       drive;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       rd_done;
    logic [7:0] rdv;
  } cyc_t;

  cyc_t       sched[$];
  cyc_t       cur;
  bit         cur_idle = 1'b1;
  logic [7:0] m_rdata  = 8'h00;

  // Expand one accepted request into W+1 access cycles, a ready cycle and,
  // for writes with turnaround, one all-quiet cycle.
  function automatic void plan_access();
    int   idx;
    int   w;
    cyc_t r;
    idx = int'(addr[6:5]);
    w   = int'(cfg[idx]);
    for (int i = 0; i <= w; i++) begin
      r.sel = 4'(1 << idx); r.we = we; r.oe = we ? 8'hFF : 8'h00; r.rdy = 1'b0;
      r.drive = 1'b1; r.addr = addr; r.wdata = wdata; r.rd_done = 1'b0; r.rdv = 8'h00;
      sched.push_back(r);
    end
    r.sel = 4'(1 << idx); r.we = 1'b0; r.oe = we ? 8'hFF : 8'h00; r.rdy = 1'b1;
    r.drive = 1'b0; r.addr = addr; r.wdata = wdata; r.rd_done = !we; r.rdv = devd[idx];
    sched.push_back(r);
    if (TURN_EN && we) begin
      r.sel = 4'h0; r.we = 1'b0; r.oe = 8'h00; r.rdy = 1'b0;
      r.drive = 1'b0; r.rd_done = 1'b0;
      sched.push_back(r);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      cur_idle = 1'b1;
      m_rdata  = 8'h00;
    end else begin
      if (cur_idle && req) plan_access();
      if (sched.size() > 0) begin
        cur      = sched.pop_front();
        cur_idle = 1'b0;
        if (cur.rd_done) m_rdata = cur.rdv;
      end else begin
        cur_idle = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst || cur_idle) begin
      chk("idle_sel", 32'(sel4), 32'h0);
      chk("idle_we",  32'(we4),  32'h0);
      chk("idle_oe",  32'(oe4),  32'h0);
      chk("idle_rdy", 32'(rdy4), 32'h0);
    end else begin
      chk("m_sel", 32'(sel4), 32'(cur.sel));
      chk("m_we",  32'(we4),  32'(cur.we));
      chk("m_oe",  32'(oe4),  32'(cur.oe));
      chk("m_rdy", 32'(rdy4), 32'(cur.rdy));
      if (cur.drive) begin
        chk("m_addr",  32'(baddr4),   32'(cur.addr));
        chk("m_wdata", 32'(wdata_o4), 32'(cur.wdata));
      end
    end
    chk("m_rdata", 32'(rdata4), rst ? 32'h0 : 32'(m_rdata));
  end

  // ---------------- directed stimulus ----------------
  int         t_rdy, t_we, t_oe, t_acc, t_rdy3;
  logic [3:0] t_sel1;
  logic       t_sel3;
  logic [7:0] t_after_oe;

  task automatic do_access(input logic w, input logic [6:0] a, input logic [7:0] d,
                           input int drop_after);
    t_rdy = -1; t_we = 0; t_oe = 0; t_acc = 0; t_rdy3 = -1; t_sel1 = 4'h0; t_sel3 = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);  // request sampled here: edge 0
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) t_sel1 = sel4;
      if (we4) t_we++;
      if (oe4 == 8'hFF) t_oe++;
      if (sel4 != 4'h0 && !rdy4 && baddr4 == a) t_acc++;
      if (sel3 != 3'h0) t_sel3 = 1'b1;
      if (rdy3 && t_rdy3 < 0) t_rdy3 = c;
      if (rdy4) begin
        t_rdy = c;
        break;
      end
      if (c == drop_after) begin
        @(posedge clk); #1;
        req = 1'b0;
      end
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    t_after_oe = oe4;
  endtask

  initial begin
    int   rdy_seen;
    logic [3:0] sel_seen;

    cfg[0] = 3'd0; cfg[1] = 3'd2; cfg[2] = 3'd7; cfg[3] = 3'd0;
    devd[0] = 8'hA5; devd[1] = 8'h3C; devd[2] = 8'h77; devd[3] = 8'h5A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", 32'(rdata4), 32'h0);
    chk("rst_addr",  32'(baddr4), 32'h0);
    #2 rst = 1'b0;

    // Read dev0, zero waits.
    do_access(1'b0, 7'h05, 8'h00, 0);
    chk("rd0_ready_cycle", 32'(t_rdy), 32'd2);
    chk("rd0_sel",         32'(t_sel1), 32'h1);
    chk("rd0_rdata",       32'(rdata4), 32'hA5);

    // Read dev1, two waits.
    do_access(1'b0, 7'h25, 8'h00, 0);
    chk("rd1_ready_cycle",  32'(t_rdy), 32'd4);
    chk("rd1_access_cycles", 32'(t_acc), 32'd3);
    chk("rd1_rdata",        32'(rdata4), 32'h3C);

    // Write dev2, seven waits.
    do_access(1'b1, 7'h47, 8'h99, 0);
    chk("wr2_we_cycles",    32'(t_we),  32'd8);
    chk("wr2_oe_cycles",    32'(t_oe),  32'd9);
    chk("wr2_ready_cycle",  32'(t_rdy), 32'd9);
    chk("wr2_post_oe",      32'(t_after_oe), 32'h0);
    chk("wr2_rdata_hold",   32'(rdata4), 32'h3C);

    // Write dev0, zero waits.
    do_access(1'b1, 7'h10, 8'h42, 0);
    chk("wr0_we_cycles",   32'(t_we),  32'd1);
    chk("wr0_oe_cycles",   32'(t_oe),  32'd2);
    chk("wr0_ready_cycle", 32'(t_rdy), 32'd2);

    // Read 0x60: dev3 on the 4-device instance, unmapped on the 3-device one.
    do_access(1'b0, 7'h60, 8'h00, 0);
    chk("rd3_ready_cycle",   32'(t_rdy),  32'd2);
    chk("rd3_sel",           32'(t_sel1), 32'h8);
    chk("rd3_rdata",         32'(rdata4), 32'h5A);
    chk("unmap_ready_cycle", 32'(t_rdy3), 32'd2);
    chk("unmap_sel",         32'(t_sel3), 32'h0);
    chk("unmap_rdata",       32'(rdata3), 32'h0);

    // Reset in the third access cycle of a dev2 write.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 7'h47; wdata = 8'h99;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("pre_rst_we", 32'(we4), 32'h1);
    #2 rst = 1'b1;
    req = 1'b0;
    #1;
    chk("rst_we",  32'(we4),  32'h0);
    chk("rst_oe",  32'(oe4),  32'h0);
    chk("rst_sel", 32'(sel4), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    rdy_seen = 0;
    sel_seen = 4'h0;
    repeat (6) begin
      @(negedge clk);
      if (rdy4) rdy_seen++;
      sel_seen = sel_seen | sel4;
    end
    chk("rst_no_ready", 32'(rdy_seen), 32'd0);
    chk("rst_idle_sel", 32'(sel_seen), 32'h0);

    // Request dropped after one access cycle of a dev1 read.
    do_access(1'b0, 7'h25, 8'h00, 1);
    chk("drop_ready_cycle", 32'(t_rdy), 32'd4);
    chk("drop_rdata",       32'(rdata4), 32'h3C);
    sel_seen = 4'h0;
    repeat (4) begin
      @(negedge clk);
      sel_seen = sel_seen | sel4;
    end
    chk("drop_no_new_access", 32'(sel_seen), 32'h0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
